uart_tx_cfg: RTL and testbench
==============================

// Module: uart_tx_cfg
// PURPOSE
//   Parametrised UART transmitter: serialises one word per frame onto txd as
//   start bit, DATA_BITS data bits (LSB first), optional parity, 1 or 2 stop bits.
//   Upstream loads words with a valid/ready handshake, gated by cts flow control.
//   Drop-in successor to the fixed 8N1 transmitter in the serial I/O path.
// PARAMETERS
//   CLKS_PER_BIT  87  clk cycles per bit period; legal range >= 2
//   DATA_BITS     8   data bits per frame; legal range 5..9
//   PARITY        0   0 = none, 1 = odd, 2 = even
//   STOP_BITS     1   stop bits per frame; legal values 1 or 2
//   Illegal parameter values are an elaboration error.
// PORTS
//   clk       in   1          clock
//   reset     in   1          synchronous, active-high reset
//   tx_data   in   DATA_BITS  word to send; sampled only on acceptance
//   tx_valid  in   1          tx_data is valid
//   tx_ready  out  1          block accepts a word this cycle
//   cts       in   1          clear-to-send, active-high; checked only at acceptance
//   txd       out  1          serial line; idles high
//   busy      out  1          frame in progress (state != IDLE)
//   tx_done   out  1          one-cycle pulse when a frame's last stop bit ends
// BEHAVIOUR
//   Reset, synchronous, active-high, on clk: state=IDLE, txd=1, tx_done=0,
//     busy=0, counters=0. tx_ready=0 while reset is high.
//   Reset mid-frame abandons the frame. txd is 1 on the next edge.
//   States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   tx_ready = (state==IDLE) && cts && !reset. This is combinational from
//     registered state.
//   Accept: tx_valid && tx_ready at edge N. On that edge:
//     - latch tx_data into the shift register;
//     - latch the parity bit (odd: ~^data, even: ^data);
//     - state <= START; txd <= 0.
//     So txd is low from cycle N+1: one-cycle accept-to-line latency.
//   Each bit is held on txd for exactly CLKS_PER_BIT cycles. A baud counter of
//     width $clog2(CLKS_PER_BIT) runs 0..CLKS_PER_BIT-1. The bit boundary
//     is at terminal count.
//   DATA: bit index 0..DATA_BITS-1 carries data[index].
//     - After the last data bit, go to PARITY if PARITY != 0, else to STOP.
//   PARITY: one bit period carrying the latched parity bit.
//   STOP: STOP_BITS*CLKS_PER_BIT cycles with txd=1.
//     - At the terminal count of the last stop bit: state <= IDLE and
//       tx_done <= 1 for exactly one cycle.
//   Back-to-back: the earliest next accept is the first IDLE cycle, the same
//     cycle tx_done is high. Frame period is therefore
//     (1 + DATA_BITS + (PARITY!=0) + STOP_BITS)*CLKS_PER_BIT + 1 cycles.
//   cts low in IDLE: no accept; txd stays 1; tx_valid may be held indefinitely.
//   cts falling mid-frame: ignored. The current frame completes unaltered.
//   tx_data and tx_valid changes after acceptance have no effect on the frame.
//   No encoding other than the listed states is reachable. Any illegal
//     encoding returns to IDLE with txd=1 on the next edge.
// TESTING
//   1. CLKS_PER_BIT=4, 8N1, send 0xA5
//      -> txd = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles;
//      -> tx_done pulses at cycle 41 after the accept edge.
//   2. DATA_BITS=7, send 0x55
//      -> PARITY=2: parity bit 0; PARITY=1: parity bit 1;
//      -> frame is 10 bit periods.
//   3. STOP_BITS=2, tx_valid held high with 0x00 then 0xFF
//      -> 2nd accept is in the tx_done cycle;
//      -> start bits are exactly 1+11*CLKS_PER_BIT cycles apart.
//   4. cts=0 with tx_valid=1 for 20 cycles -> tx_ready=0, txd=1, busy=0.
//      Raise cts -> accept on that cycle. Drop cts in DATA -> frame completes.
//   5. reset in DATA bit 3
//      -> txd=1 and busy=0 next cycle;
//      -> after reset is released, 0x3C is sent bit-exact.
//   6. Change tx_data every cycle after acceptance
//      -> serialised word equals the value at the accept edge.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional odd/even parity, 1 or 2 stop bits, valid/ready load gated by cts.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 cts,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done,
  output logic [2:0]           dbg_state_o
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 state_q;
  logic                   txd_q;
  logic                   done_q;
  logic [CNT_W-1:0]       baud_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   stop_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_q;
  logic                   baud_end;

  // Handshake: a word transfers on any clk edge where tx_valid && tx_ready;
  // tx_ready only rises in IDLE with cts high and reset low, and tx_data is
  // sampled on that edge alone.
  assign tx_ready    = (state_q == S_IDLE) && cts && !reset;
  assign txd         = txd_q;
  assign tx_done     = done_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;
  assign baud_end    = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
      baud_q  <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          txd_q  <= 1'b1;
          baud_q <= '0;
          idx_q  <= '0;
          stop_q <= 1'b0;
          if (tx_valid && tx_ready) begin
            shift_q <= tx_data;
            par_q   <= (PARITY == 1) ? ~^tx_data : ^tx_data;
            state_q <= S_START;
            txd_q   <= 1'b0;
          end
        end
        S_START: begin
          if (baud_end) begin
            baud_q  <= '0;
            state_q <= S_DATA;
            txd_q   <= shift_q[0];
            shift_q <= shift_q >> 1;
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (idx_q == DATA_LAST) begin
              if (PARITY != 0) begin
                state_q <= S_PARITY;
                txd_q   <= par_q;
              end else begin
                state_q <= S_STOP;
                txd_q   <= 1'b1;
              end
            end else begin
              // shift_q already advanced, so bit 0 is the next data bit
              idx_q   <= idx_q + IDX_W'(1);
              txd_q   <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (baud_end) begin
            baud_q  <= '0;
            state_q <= S_STOP;
            txd_q   <= 1'b1;
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          txd_q <= 1'b1;
          if (baud_end) begin
            baud_q <= '0;
            if (stop_q == STOP_LAST) begin
              state_q <= S_IDLE;
              stop_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              stop_q <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four configurations side by side, each frame checked
// cycle by cycle against a bit list built from the framing rules.
module tb_uart_tx_cfg;

  localparam int N = 4;
  localparam int CPB_C [N] = '{4, 3, 5, 2};
  localparam int DB_C  [N] = '{8, 7, 7, 9};
  localparam int PAR_C [N] = '{0, 2, 1, 1};
  localparam int SB_C  [N] = '{1, 2, 1, 2};

  logic       clk = 1'b0;
  logic       reset;
  logic       cts;
  logic       tx_valid  [N];
  logic [8:0] tx_data   [N];
  logic       tx_ready  [N];
  logic       txd       [N];
  logic       busy      [N];
  logic       tx_done   [N];
  logic [2:0] dbg_state [N];

  logic exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  uart_tx_cfg #(.CLKS_PER_BIT(CPB_C[0]), .DATA_BITS(DB_C[0]), .PARITY(PAR_C[0]), .STOP_BITS(SB_C[0])) u_dut0 (
    .clk(clk), .reset(reset), .tx_data(tx_data[0][7:0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .cts(cts), .txd(txd[0]), .busy(busy[0]),
    .tx_done(tx_done[0]), .dbg_state_o(dbg_state[0])
  );
  uart_tx_cfg #(.CLKS_PER_BIT(CPB_C[1]), .DATA_BITS(DB_C[1]), .PARITY(PAR_C[1]), .STOP_BITS(SB_C[1])) u_dut1 (
    .clk(clk), .reset(reset), .tx_data(tx_data[1][6:0]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .cts(cts), .txd(txd[1]), .busy(busy[1]),
    .tx_done(tx_done[1]), .dbg_state_o(dbg_state[1])
  );
  uart_tx_cfg #(.CLKS_PER_BIT(CPB_C[2]), .DATA_BITS(DB_C[2]), .PARITY(PAR_C[2]), .STOP_BITS(SB_C[2])) u_dut2 (
    .clk(clk), .reset(reset), .tx_data(tx_data[2][6:0]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .cts(cts), .txd(txd[2]), .busy(busy[2]),
    .tx_done(tx_done[2]), .dbg_state_o(dbg_state[2])
  );
  uart_tx_cfg #(.CLKS_PER_BIT(CPB_C[3]), .DATA_BITS(DB_C[3]), .PARITY(PAR_C[3]), .STOP_BITS(SB_C[3])) u_dut3 (
    .clk(clk), .reset(reset), .tx_data(tx_data[3][8:0]), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .cts(cts), .txd(txd[3]), .busy(busy[3]),
    .tx_done(tx_done[3]), .dbg_state_o(dbg_state[3])
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference frame: start 0, data LSB first, parity from the count of ones, stop 1s.
  task automatic build_frame(input int d, input logic [8:0] data);
    int ones;
    exp_q.delete();
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < DB_C[d]; i++) begin
      exp_q.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (PAR_C[d] == 2) exp_q.push_back((ones % 2) == 1);
    if (PAR_C[d] == 1) exp_q.push_back((ones % 2) == 0);
    for (int i = 0; i < SB_C[d]; i++) exp_q.push_back(1'b1);
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < N; d++) begin
      check($sformatf("d%0d_rst_txd", d), txd[d], 1'b1);
      check($sformatf("d%0d_rst_busy", d), busy[d], 1'b0);
      check($sformatf("d%0d_rst_done", d), tx_done[d], 1'b0);
      check($sformatf("d%0d_rst_ready", d), tx_ready[d], 1'b0);
    end
    reset = 1'b0;
  endtask

  task automatic idle_cycles(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("d%0d_idle_txd", d), txd[d], 1'b1);
      check($sformatf("d%0d_idle_busy", d), busy[d], 1'b0);
    end
  endtask

  // Sends one word and checks every cycle of its frame. Called just after a
  // posedge; returns just after the tx_done edge (hold=1) or one cycle later.
  task automatic run_frame(input int d, input logic [8:0] data, input bit hold,
                           input logic [8:0] nxt, input bit scramble,
                           input bit drop_cts, input int abort_k);
    int  cpb;
    int  len;
    int  waited;
    logic cur;
    cpb = CPB_C[d];
    build_frame(d, data);
    len = exp_q.size() * cpb;
    tx_data[d]  = data;
    tx_valid[d] = 1'b1;
    for (waited = 0; waited < 50; waited++) begin
      @(negedge clk);
      if (tx_ready[d] === 1'b1) break;
    end
    check($sformatf("d%0d_accept_wait", d), waited, 0);
    if (waited >= 50) begin
      tx_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (hold) tx_data[d] = nxt;
    else tx_valid[d] = 1'b0;
    cur = 1'b1;
    for (int k = 0; k < len; k++) begin
      if (k % cpb == 0) cur = exp_q.pop_front();
      check($sformatf("d%0d_txd_k%0d", d, k), txd[d], cur);
      check($sformatf("d%0d_busy_k%0d", d, k), busy[d], 1'b1);
      check($sformatf("d%0d_done_k%0d", d, k), tx_done[d], 1'b0);
      check($sformatf("d%0d_ready_k%0d", d, k), tx_ready[d], 1'b0);
      if (k == abort_k) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("d%0d_abort_txd", d), txd[d], 1'b1);
        check($sformatf("d%0d_abort_busy", d), busy[d], 1'b0);
        check($sformatf("d%0d_abort_done", d), tx_done[d], 1'b0);
        check($sformatf("d%0d_abort_ready", d), tx_ready[d], 1'b0);
        reset = 1'b0;
        return;
      end
      if (scramble) begin
        tx_data[d]  = 9'($urandom);
        tx_valid[d] = 1'($urandom_range(0, 1));
      end
      if (drop_cts && k == 3 * cpb) cts = 1'b0;
      @(posedge clk);
      #1;
    end
    check($sformatf("d%0d_end_done", d), tx_done[d], 1'b1);
    check($sformatf("d%0d_end_busy", d), busy[d], 1'b0);
    check($sformatf("d%0d_end_txd", d), txd[d], 1'b1);
    check($sformatf("d%0d_end_ready", d), tx_ready[d], cts);
    tx_valid[d] = hold;
    if (hold) tx_data[d] = nxt;
    if (!hold) begin
      @(posedge clk);
      #1;
      check($sformatf("d%0d_post_done", d), tx_done[d], 1'b0);
      check($sformatf("d%0d_post_busy", d), busy[d], 1'b0);
      check($sformatf("d%0d_post_txd", d), txd[d], 1'b1);
    end
    if (drop_cts) cts = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [8:0] data;
    logic [8:0] nxt;
    bit         hold;
    reset = 1'b1;
    cts   = 1'b1;
    for (int d = 0; d < N; d++) begin
      tx_valid[d] = 1'b0;
      tx_data[d]  = '0;
    end
    do_reset();

    // 8N1 0xA5, then 7-bit 0x55 with even and odd parity
    run_frame(0, 9'h0A5, 1'b0, 9'h0, 1'b0, 1'b0, -1);
    run_frame(1, 9'h055, 1'b0, 9'h0, 1'b0, 1'b0, -1);
    run_frame(2, 9'h055, 1'b0, 9'h0, 1'b0, 1'b0, -1);

    // two stop bits, valid held: 0x00 then 0xFF back to back
    run_frame(1, 9'h000, 1'b1, 9'h0FF, 1'b0, 1'b0, -1);
    run_frame(1, 9'h0FF, 1'b0, 9'h0, 1'b0, 1'b0, -1);

    // cts low blocks acceptance; raising it accepts at once; dropping it mid-frame is ignored
    cts         = 1'b0;
    tx_data[0]  = 9'h0C3;
    tx_valid[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("cts_low_ready", tx_ready[0], 1'b0);
      check("cts_low_txd", txd[0], 1'b1);
      check("cts_low_busy", busy[0], 1'b0);
    end
    @(posedge clk);
    #1;
    cts = 1'b1;
    run_frame(0, 9'h0C3, 1'b0, 9'h0, 1'b0, 1'b1, -1);

    // reset during data bit 3, then a clean 0x3C
    run_frame(0, 9'($urandom), 1'b0, 9'h0, 1'b0, 1'b0, 4 * CPB_C[0] + 1);
    run_frame(0, 9'h03C, 1'b0, 9'h0, 1'b0, 1'b0, -1);

    // inputs scrambled after acceptance
    run_frame(0, 9'h096, 1'b0, 9'h0, 1'b1, 1'b0, -1);

    // randomized traffic on every configuration
    for (int d = 0; d < N; d++) begin
      data = 9'($urandom);
      for (int r = 0; r < 6; r++) begin
        nxt  = 9'($urandom);
        hold = (r < 5) && ($urandom_range(0, 1) == 1);
        run_frame(d, data, hold, nxt, 1'($urandom_range(0, 1)), 1'b0, -1);
        data = nxt;
        if (!hold) idle_cycles(d, $urandom_range(0, 3));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
